// File: rtl/rr_arb_mux.sv
// Registered N-to-1 arbitrating mux: round-robin or fixed-priority grant, one registered output stage.
// One-cycle latency, full throughput; in_ready is withheld from every channel while the output beat is stalled.
module rr_arb_mux #(
  parameter int SEL_WIDTH = 2,
  parameter int W         = 32,
  parameter bit RR_MODE   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [(1<<SEL_WIDTH)-1:0]   in_valid,
  input  logic [(1<<SEL_WIDTH)*W-1:0] in_data,
  output logic [(1<<SEL_WIDTH)-1:0]   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_data,
  output logic [SEL_WIDTH-1:0]   out_sel
);
  localparam int N = 1 << SEL_WIDTH;

  logic                 load;
  logic                 found;
  logic [SEL_WIDTH-1:0] gnt;
  logic [SEL_WIDTH-1:0] ptr;

  assign load = !out_valid || out_ready;

  // Search starts at ptr; in fixed-priority mode ptr never leaves 0, so the
  // same scan yields the lowest requesting index.
  always_comb begin : arb
    logic [SEL_WIDTH-1:0] idx;
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = ptr + SEL_WIDTH'(i);
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (rst_n && load && found) in_ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (found) begin
        out_valid <= 1'b1;
        out_data  <= in_data[gnt*W +: W];
        out_sel   <= gnt;
        if (RR_MODE) ptr <= gnt + 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: one round-robin and one fixed-priority instance against a queue-free behavioural model.
module tb_rr_arb_mux;
  localparam int N = 4;
  localparam int W = 32;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   r_valid, f_valid;
  logic [N*W-1:0] r_data, f_data;
  logic [N-1:0]   r_rdy, f_rdy;
  logic           r_ovld, f_ovld, r_ordy, f_ordy;
  logic [W-1:0]   r_odat, f_odat;
  logic [1:0]     r_osel, f_osel;

  rr_arb_mux #(.SEL_WIDTH(2), .W(W), .RR_MODE(1'b1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(r_valid), .in_data(r_data), .in_ready(r_rdy),
    .out_valid(r_ovld), .out_ready(r_ordy), .out_data(r_odat), .out_sel(r_osel));

  rr_arb_mux #(.SEL_WIDTH(2), .W(W), .RR_MODE(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .in_valid(f_valid), .in_data(f_data), .in_ready(f_rdy),
    .out_valid(f_ovld), .out_ready(f_ordy), .out_data(f_odat), .out_sel(f_osel));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Model state: registered beat and rotation pointer of each instance
  bit          mr_v, mf_v;
  logic [31:0] mr_d, mf_d;
  int          mr_s, mf_s, mr_p;

  // Upstream hold tracking for the round-robin instance
  bit             hold_en = 0;
  logic [N-1:0]   hv_prev, hr_prev;
  logic [N*W-1:0] hd_prev;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++)
      if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic model_reset();
    mr_v = 0; mr_d = 0; mr_s = 0; mr_p = 0;
    mf_v = 0; mf_d = 0; mf_s = 0;
  endtask

  // Checks outputs at the falling edge, then advances the model over the rising edge.
  task automatic step(input string tag);
    int gr, gf;
    logic [N-1:0] er, ef;
    @(negedge clk);
    if (!rst_n) model_reset();
    gr = (rst_n && (!mr_v || r_ordy)) ? pick(r_valid, mr_p) : -1;
    gf = (rst_n && (!mf_v || f_ordy)) ? pick(f_valid, 0) : -1;
    er = '0; ef = '0;
    if (gr >= 0) er[gr] = 1'b1;
    if (gf >= 0) ef[gf] = 1'b1;
    chk({tag, ".rr_in_ready"}, 64'(r_rdy), 64'(er));
    chk({tag, ".rr_out_valid"}, 64'(r_ovld), 64'(mr_v));
    chk({tag, ".rr_out_data"}, 64'(r_odat), 64'(mr_d));
    chk({tag, ".rr_out_sel"}, 64'(r_osel), 64'(mr_s));
    chk({tag, ".fp_in_ready"}, 64'(f_rdy), 64'(ef));
    chk({tag, ".fp_out_valid"}, 64'(f_ovld), 64'(mf_v));
    chk({tag, ".fp_out_data"}, 64'(f_odat), 64'(mf_d));
    chk({tag, ".fp_out_sel"}, 64'(f_osel), 64'(mf_s));
    if (hold_en)
      for (int k = 0; k < N; k++)
        if (hv_prev[k] && !hr_prev[k])
          chk({tag, ".upstream_hold"}, {31'(0), r_valid[k], r_data[k*W +: W]},
              {31'(0), 1'b1, hd_prev[k*W +: W]});
    hv_prev = r_valid; hr_prev = r_rdy; hd_prev = r_data;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      if (gr >= 0) begin
        mr_v = 1; mr_d = r_data[gr*W +: W]; mr_s = gr; mr_p = (gr + 1) % N;
      end else if (!mr_v || r_ordy) mr_v = 0;
      if (gf >= 0) begin
        mf_v = 1; mf_d = f_data[gf*W +: W]; mf_s = gf;
      end else if (!mf_v || f_ordy) mf_v = 0;
    end
    #1;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    r_valid = 4'b1111; f_valid = 4'b1111;
    r_data = '0; f_data = '0;
    r_ordy = 1'b1; f_ordy = 1'b1;
    #1;
    step("reset"); step("reset");

    rst_n = 1'b1; r_valid = '0; f_valid = '0;
    step("idle"); step("idle");

    // Single request on channel 2
    r_data[2*W +: W] = 32'hDEADBEEF;
    r_valid = 4'b0100;
    step("single_req");
    r_valid = '0;
    step("single_out");

    // Rotation with all channels requesting; fixed instance sees 1010
    for (int k = 0; k < N; k++) begin
      r_data[k*W +: W] = 32'h11 * k;
      f_data[k*W +: W] = 32'hA0 + k;
    end
    r_valid = 4'b1111; f_valid = 4'b1010;
    for (int i = 0; i < 5; i++) step("rotate");

    // Advance until channel 1 is on the output, then stall for three cycles
    for (int i = 0; i < 8 && !(mr_v && mr_s == 1); i++) step("seek_ch1");
    chk("seek_ch1_reached", 64'(r_osel), 64'd1);
    r_ordy = 1'b0;
    for (int i = 0; i < 3; i++) step("backpressure");
    r_ordy = 1'b1;
    step("release"); step("release");

    // Grant channel 3, then reset while the beat is still pending
    r_valid = 4'b1000; r_ordy = 1'b0;
    for (int i = 0; i < 4 && !(mr_v && mr_s == 3); i++) begin
      r_ordy = 1'b1; step("to_ch3");
    end
    r_ordy = 1'b0;
    rst_n = 1'b0;
    step("mid_reset");
    rst_n = 1'b1; r_ordy = 1'b1; r_valid = 4'b1001;
    step("after_reset"); step("after_reset"); step("after_reset");

    // Randomized traffic; round-robin sources honour the hold obligation
    r_valid = '0;
    step("rand_start");
    hold_en = 1;
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) begin
        if (!r_valid[k] || hr_prev[k]) begin
          r_valid[k] = ($urandom_range(0, 2) != 0);
          r_data[k*W +: W] = $urandom;
        end
      end
      f_valid = 4'($urandom);
      for (int k = 0; k < N; k++) f_data[k*W +: W] = $urandom;
      r_ordy = ($urandom_range(0, 3) != 0);
      f_ordy = ($urandom_range(0, 3) != 0);
      step("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
Registered N-to-1 arbitrating multiplexer with valid/ready handshakes on every input channel and on the output. It selects one requesting channel per cycle, either round-robin or fixed-priority, and registers that channel's data and index into a single output stage. It serves the cache controller wherever several sources compete for one downstream path, such as miss, writeback and snoop requests feeding the memory interface.

Parameters:
SEL_WIDTH, 2, select index width; channel count N = 2^SEL_WIDTH
W, 32, data width per channel and of the output
RR_MODE, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  N  per-channel request; bit k belongs to channel k
in_data  input  N*W  concatenated channel data; channel k occupies [k*W +: W]
in_ready  output  N  per-channel accept; at most one bit high per cycle
out_valid  output  1  output register holds a valid beat
out_ready  input  1  downstream accepts the output beat
out_data  output  W  registered data of the granted channel
out_sel  output  SEL_WIDTH  registered index of the channel that produced out_data

Behaviour:
- Reset (async assert, sync deassert handled externally): out_valid=0, out_data=0, out_sel=0, priority pointer ptr=0. in_ready is 0 while rst_n=0.
- load = !out_valid || out_ready. This is combinational, so full throughput is allowed: one beat per cycle.
- Arbitration (combinational, only when load=1):
  - RR_MODE=1: grant the first k with in_valid[k]=1, searching ptr, ptr+1, …, ptr+N-1 with modulo-N wrap.
  - RR_MODE=0: grant the lowest k with in_valid[k]=1. ptr is unused and stays 0.
- in_ready[g]=1 only for the granted channel g, and only when load=1. All other bits are 0. in_ready may depend combinationally on in_valid and out_ready.
- Transfer: a channel transfer occurs on in_valid[g] && in_ready[g].
- On a clock edge with a grant: out_data <= in_data[g*W +: W], out_sel <= g, out_valid <= 1. In RR_MODE=1, ptr <= (g+1) mod N, wrapping from N-1 to 0.
- On a clock edge with load=1 and no in_valid bits set: out_valid <= 0. out_data and out_sel hold their old values. ptr is unchanged.
- On a clock edge with load=0 (out_valid=1, out_ready=0): out_valid, out_data, out_sel and ptr hold. All in_ready bits are 0 (backpressure).
- Latency: an accepted input appears on out_* in the following cycle.
- Data stability: once out_valid=1, out_data and out_sel do not change until out_ready=1.
- Fairness (RR_MODE=1): with all N channels continuously valid and out_ready=1, grants cycle 0,1,…,N-1,0,…. No channel waits more than N-1 grants.
- Channel hold: a channel that raises in_valid must hold it and its data until it sees in_ready. This is an upstream obligation, flagged by a bench assertion and not checked in RTL.
- Reset mid-operation: a pending output beat is dropped (out_valid→0 immediately) and ptr returns to 0.
- ptr update width: ptr is SEL_WIDTH bits, so the mod-N update is natural overflow.

Test Plan:
- Reset/idle: hold rst_n=0 with in_valid=4'b1111, then release with in_valid=0 → during reset out_valid=0, in_ready=0, out_data=0, out_sel=0; after release out_valid stays 0.
- Single request, N=4, W=32: in_valid=4'b0100, in_data channel 2 = 0xDEADBEEF, out_ready=1 → in_ready=4'b0100 in the same cycle; next cycle out_valid=1, out_data=0xDEADBEEF, out_sel=2.
- Round-robin rotation: in_valid=4'b1111 held, out_ready=1, RR_MODE=1 → out_sel sequence 0,1,2,3,0 on consecutive cycles, with one in_ready bit per cycle.
- Fixed priority: RR_MODE=0, in_valid=4'b1010 held, out_ready=1 → out_sel=1 on every cycle; channel 3 is never granted.
- Backpressure: with out_valid=1, out_sel=1, out_data=0x11, drive out_ready=0 for 3 cycles with in_valid=4'b1111 → in_ready=0 and out_data/out_sel hold. On the cycle out_ready=1, in_ready=4'b0100 (ptr=2) and the next out_sel=2.
- Wrap and reset mid-stream: after a grant to channel 3 (ptr=0), assert rst_n=0 while out_valid=1 → out_valid drops immediately. After release with in_valid=4'b1001, the first grant is channel 0 and the second is channel 3.
